// File: rtl/key_list_pkg.sv
// Shared defaults and helpers for the key history lists.
package key_list_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned KEY_W_DEF = 8;

  typedef logic [KEY_W_DEF-1:0] key_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/key_shift_list.sv
// Shift-register key history: slot 0 newest, synchronous clear, saturating fill count.
module key_shift_list
  import key_list_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic                          we_i,
  input  logic [KEY_W-1:0]              key_i,
  output logic [DEPTH-1:0][KEY_W-1:0]   slots_o,
  output logic [cnt_w(DEPTH)-1:0]       count_o
);

  localparam int unsigned CW = cnt_w(DEPTH);

  logic [DEPTH-1:0][KEY_W-1:0] slots_q, slots_d;
  logic [CW-1:0]               count_q, count_d;

  // Clear is applied first so a write on the same edge lands in an empty list.
  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    if (clr_i) begin
      slots_d = '0;
      count_d = '0;
    end
    if (we_i) begin
      slots_d = {slots_d[DEPTH-2:0], key_i};
      if (count_d != CW'(DEPTH)) begin
        count_d = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slots_q <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  assign slots_o = slots_q;
  assign count_o = count_q;

endmodule

// File: rtl/key_list.sv
// Keypad press capture into code/entry histories with registered combination match.
module key_list
  import key_list_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic                    hwclk,
  input  logic                    reset,
  input  logic [KEY_W-1:0]        key,
  input  logic                    button_pressed,
  input  logic [31:0]             typed,
  input  logic                    enable,
  output logic                    key_valid,
  output logic [KEY_W-1:0]        last_key,
  output logic [cnt_w(DEPTH)-1:0] code_count,
  output logic [cnt_w(DEPTH)-1:0] entry_count,
  output logic                    match
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                        press_q;
  logic                        arm_q;
  logic                        enable_q;
  logic                        key_valid_q;
  logic [KEY_W-1:0]            last_key_q, last_key_d;
  logic                        match_q, match_d;

  logic                        accept;
  logic                        en_rise;
  logic                        code_we, entry_we;
  logic [31:0]                 l_eff;
  logic                        hit;
  logic [DEPTH-1:0][KEY_W-1:0] code_slots, entry_slots;

  // arm_q stays low after reset until the button is seen released, so a key
  // still held through reset is not taken as a fresh press.
  always_comb begin
    accept     = button_pressed & ~press_q & arm_q;
    en_rise    = enable & ~enable_q;
    code_we    = accept & ~enable;
    entry_we   = accept & enable;
    last_key_d = accept ? key : last_key_q;
  end

  always_comb begin
    l_eff = (typed > DEPTH) ? DEPTH : typed;
    hit   = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((i < l_eff) && (entry_slots[i[IW-1:0]] != code_slots[i[IW-1:0]])) begin
        hit = 1'b0;
      end
    end
    match_d = enable && !en_rise && (l_eff != 32'd0) &&
              (32'(entry_count) >= l_eff) && (32'(code_count) >= l_eff) && hit;
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      press_q     <= 1'b0;
      arm_q       <= 1'b0;
      enable_q    <= 1'b0;
      key_valid_q <= 1'b0;
      last_key_q  <= '0;
      match_q     <= 1'b0;
    end else begin
      press_q     <= button_pressed;
      arm_q       <= arm_q | ~button_pressed;
      enable_q    <= enable;
      key_valid_q <= accept;
      last_key_q  <= last_key_d;
      match_q     <= match_d;
    end
  end

  key_shift_list #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_code (
    .clk_i   (hwclk),
    .rst_i   (reset),
    .clr_i   (1'b0),
    .we_i    (code_we),
    .key_i   (key),
    .slots_o (code_slots),
    .count_o (code_count)
  );

  key_shift_list #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_entry (
    .clk_i   (hwclk),
    .rst_i   (reset),
    .clr_i   (en_rise),
    .we_i    (entry_we),
    .key_i   (key),
    .slots_o (entry_slots),
    .count_o (entry_count)
  );

  assign key_valid = key_valid_q;
  assign last_key  = last_key_q;
  assign match     = match_q;

endmodule

// File: tb/tb_key_list.sv
// Bench for key_list: press table with hand-derived results, corner sequences, random vs queue model.
module tb_key_list;
  import key_list_pkg::*;

  localparam int D = 16;

  logic        hwclk = 1'b0;
  logic        reset = 1'b0;
  key_t        key = '0;
  logic        button_pressed = 1'b0;
  logic [31:0] typed = 32'd3;
  logic        enable = 1'b0;
  logic        key_valid;
  key_t        last_key;
  logic [4:0]  code_count, entry_count;
  logic        match;

  key_list #(.DEPTH(D), .KEY_W(8)) dut (
    .hwclk          (hwclk),
    .reset          (reset),
    .key            (key),
    .button_pressed (button_pressed),
    .typed          (typed),
    .enable         (enable),
    .key_valid      (key_valid),
    .last_key       (last_key),
    .code_count     (code_count),
    .entry_count    (entry_count),
    .match          (match)
  );

  always #5 hwclk = ~hwclk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: lists as queues, element 0 newest.
  int m_code[$];
  int m_entry[$];
  int m_last, m_kv, m_match;
  bit m_prev_b, m_prev_en, m_armed;

  typedef struct {
    bit rst; bit en; int typ; int k; int hold;
    int cc; int ec; int last; int m;
  } vec_t;
  vec_t vecs[$];

  int wk[17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int tk[16] = '{2, 3, 4, 5, 6, 7, 8, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int tsel[7] = '{0, 1, 2, 3, 5, 16, 40};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_match(input int t, input bit e);
    int l;
    l = (t > D) ? D : t;
    if (!e || l == 0) return 0;
    if (m_entry.size() < l || m_code.size() < l) return 0;
    for (int i = 0; i < l; i++)
      if (m_entry[i] != m_code[i]) return 0;
    return 1;
  endfunction

  function automatic void model_reset();
    m_code.delete(); m_entry.delete();
    m_last = 0; m_kv = 0; m_match = 0;
    m_prev_b = 0; m_prev_en = 0; m_armed = 0;
  endfunction

  function automatic void model_edge(input bit b, input int k, input int t, input bit e);
    bit acc, rise;
    int mn;
    rise = e && !m_prev_en;
    mn   = rise ? 0 : model_match(t, e);
    acc  = b && !m_prev_b && m_armed;
    if (rise) m_entry.delete();
    if (acc) begin
      if (e) begin
        m_entry.push_front(k);
        if (m_entry.size() > D) void'(m_entry.pop_back());
      end else begin
        m_code.push_front(k);
        if (m_code.size() > D) void'(m_code.pop_back());
      end
      m_last = k;
    end
    m_kv      = acc;
    m_match   = mn;
    m_armed   = m_armed || !b;
    m_prev_b  = b;
    m_prev_en = e;
  endfunction

  task automatic check_model();
    chk("key_valid", int'(key_valid), m_kv);
    chk("last_key", int'(last_key), m_last);
    chk("code_count", int'(code_count), m_code.size());
    chk("entry_count", int'(entry_count), m_entry.size());
    chk("match", int'(match), m_match);
  endtask

  task automatic step(input bit b, input int k, input int t, input bit e);
    button_pressed = b;
    key            = key_t'(k);
    typed          = t;
    enable         = e;
    @(posedge hwclk);
    model_edge(b, k, t, e);
    #1;
    check_model();
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    repeat (2) @(posedge hwclk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    button_pressed = 1'b0;
    mid_reset();
    step(0, 0, 3, 0);
    step(0, 0, 3, 0);
  endtask

  task automatic press(input bit en, input int typ, input int k, input int hold);
    int pulses;
    pulses = 0;
    for (int c = 0; c < hold; c++) begin
      step(1, k, typ, en);
      if (key_valid) pulses++;
    end
    for (int c = 0; c < 2; c++) begin
      step(0, k, typ, en);
      if (key_valid) pulses++;
    end
    chk("kv_pulses", pulses, 1);
  endtask

  function automatic void add(input bit r, input bit en, input int typ, input int k,
                              input int hold, input int cc, input int ec,
                              input int last, input int m);
    vec_t v;
    v.rst = r; v.en = en; v.typ = typ; v.k = k; v.hold = hold;
    v.cc = cc; v.ec = ec; v.last = last; v.m = m;
    vecs.push_back(v);
  endfunction

  initial begin
    int pulses;
    bit rb;
    int rk, rt;
    bit re;

    // Program 1..9, unlock 7,8,9, mismatch then recover.
    for (int k = 1; k <= 9; k++) add(k == 1, 0, 3, k, 3, k, 0, k, 0);
    add(0, 1, 3, 7, 3, 9, 1, 7, 0);
    add(0, 1, 3, 8, 3, 9, 2, 8, 0);
    add(0, 1, 3, 9, 3, 9, 3, 9, 1);
    add(0, 1, 3, 7, 3, 9, 4, 7, 0);
    add(0, 1, 3, 8, 3, 9, 5, 8, 0);
    add(0, 1, 3, 5, 3, 9, 6, 5, 0);
    add(0, 1, 3, 8, 3, 9, 7, 8, 0);
    add(0, 1, 3, 9, 3, 9, 8, 9, 0);
    add(0, 1, 3, 7, 3, 9, 9, 7, 0);
    add(0, 1, 3, 8, 3, 9, 10, 8, 0);
    add(0, 1, 3, 9, 3, 9, 11, 9, 1);
    // Wrap: 17 code presses into 16 slots.
    for (int i = 0; i < 17; i++) add(i == 0, 0, 3, wk[i], 3, (i + 1 > 16) ? 16 : i + 1, 0, wk[i], 0);
    // typed=40 behaves as a 16-key compare over the full list.
    for (int i = 0; i < 16; i++) add(0, 1, 40, tk[i], 2, 16, i + 1, tk[i], (i == 15) ? 1 : 0);

    #2;
    do_reset();

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      press(vecs[n].en, vecs[n].typ, vecs[n].k, vecs[n].hold);
      chk($sformatf("tbl%0d_code_count", n), int'(code_count), vecs[n].cc);
      chk($sformatf("tbl%0d_entry_count", n), int'(entry_count), vecs[n].ec);
      chk($sformatf("tbl%0d_last_key", n), int'(last_key), vecs[n].last);
      chk($sformatf("tbl%0d_match", n), int'(match), vecs[n].m);
    end

    // Compare length sweep on equal full lists.
    step(0, 0, 0, 1);  chk("typed0_match", int'(match), 0);
    step(0, 0, 0, 1);  chk("typed0_hold", int'(match), 0);
    step(0, 0, 16, 1); chk("typed16_match", int'(match), 1);
    step(0, 0, 1, 1);  chk("typed1_match", int'(match), 1);

    // Long hold: one accept only; newest slots still equal for L=1.
    press(1, 1, 0, 10);
    chk("long_entry_count", int'(entry_count), 16);
    chk("long_match", int'(match), 1);
    step(0, 0, 1, 0);
    chk("en_low_match", int'(match), 0);

    // Reset while a key is held.
    step(1, 8'h33, 3, 0);
    chk("pre_rst_accept", int'(key_valid), 1);
    mid_reset();
    chk("rst_code_count", int'(code_count), 0);
    chk("rst_last_key", int'(last_key), 0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step(1, 8'h55, 3, 0);
      if (key_valid) pulses++;
    end
    chk("rst_no_reaccept", pulses, 0);
    step(0, 8'h55, 3, 0);
    step(1, 8'h44, 3, 0);
    chk("post_rst_accept", int'(key_valid), 1);
    chk("post_rst_last_key", int'(last_key), 8'h44);

    // Random traffic against the model.
    do_reset();
    rb = 0; re = 0; rt = 2;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) rb = !rb;
      if ($urandom_range(0, 59) == 0) re = !re;
      if ($urandom_range(0, 39) == 0) rt = tsel[$urandom_range(0, 6)];
      rk = $urandom_range(0, 2);
      step(rb, rk, rt, re);
      if (n == 400) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_list.md
Name: key_list

Overview:
- Captures key codes from the keypad scanner, one per debounced button press, into a fixed-depth history list.
- In program mode (enable=0), presses build the stored combination (code list).
- In lock mode (enable=1), presses build an entry list. The block flags a match when the most recent `typed` entries equal the most recent `typed` code keys.
- Sits between the keypad decoder and the lock/unlock controller.

Parameters:
- DEPTH, 16, number of key slots held in each list (code and entry).
- KEY_W, 8, key code width in bits.

Ports:
- hwclk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- key  in  KEY_W  key code, sampled on an accepted press.
- button_pressed  in  1  level, high while a key is held; already debounced upstream.
- typed  in  32  combination length L, as an unsigned compare length.
- enable  in  1  0 = program mode (write code list), 1 = lock mode (write entry list).
- key_valid  out  1  one-cycle pulse on each accepted press.
- last_key  out  KEY_W  most recently accepted key.
- code_count  out  $clog2(DEPTH+1)  keys held in code list, saturating at DEPTH.
- entry_count  out  $clog2(DEPTH+1)  keys held in entry list, saturating at DEPTH.
- match  out  1  last L entries equal last L code keys.

Behaviour:
- Reset (asynchronous, active-high): all list slots 0, both counts 0, last_key 0, key_valid 0, match 0, press_q 0, enable_q 0.
- Interface: one clock, hwclk; reset is asynchronous and active-high.
- Press detection:
  - press_q registers button_pressed each cycle.
  - A press is accepted on the rising edge where button_pressed=1 and press_q=0.
  - Exactly one accept per high pulse, regardless of pulse length.
- On an accepted press:
  - key is sampled on the same edge.
  - last_key <= key and key_valid=1 for that one cycle.
  - All key values, including 0, are accepted.
- List write:
  - Each list is a shift register, slot 0 = newest.
  - On accept, the selected list shifts (slot i <= slot i-1, slot 0 <= key).
  - The list is selected by the enable value sampled at that edge.
  - Its count increments, saturating at DEPTH.
  - After DEPTH presses, the oldest key is discarded (wrap-around by shifting out).
- Mode change:
  - On an enable 0->1 transition (enable_q registered), the entry list and entry_count are cleared to 0 and match to 0.
  - The code list is untouched.
  - If a press is accepted on the same edge, clear takes priority and the press is written into the fresh entry list (entry_count = 1).
- Length rule:
  - L_eff = min(typed, DEPTH).
  - typed = 0 means match is held at 0.
- Match:
  - Registered, valid one cycle after the accepting edge.
  - Recomputed every cycle; latency 1 cycle from any list, enable or typed change.
  - match = 1 iff enable=1, L_eff >= 1, entry_count >= L_eff, code_count >= L_eff, and entry slot i == code slot i for all i < L_eff.
  - match drops to 0 when enable goes low.
- Reset mid-operation discards both lists immediately; any in-progress press is not re-accepted until button_pressed falls and rises again.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (key_list_pkg): DEPTH and KEY_W defaults, count width function, and a key_t typedef.
- One natural sub-module: key_shift_list (parameterised shift register with clear, write-enable, and saturating count), instantiated twice (code, entry).
- Edge detect and compare logic stay in the top module.

Test Plan:
- Program: enable=0, typed=3, press keys 1..9 (button high 3 clocks each) -> 9 key_valid pulses, code_count=9, last_key=9, code slots 0..2 = 9,8,7, match=0.
- Unlock: after program, enable=1, press 7,8,9 -> entry_count=3 after enable-rise clear, match=1 one cycle after the third accept.
- Mismatch: enable=1, typed=3, press 7,8,5 -> match=0; then press 8,9 -> entries 9,8,5 vs code 9,8,7 -> match=0 (mismatch at slot 2); then press 7,8,9 -> match=1 one cycle after the final accept.
- Wrap: enable=0, press 1..9 then 7 down to 0 (17 presses, DEPTH=16) -> code_count saturates at 16, newest slot 0 = 0, key 1 discarded.
- Long hold: button_pressed high 10 clocks -> exactly one key_valid; typed=0 -> match stays 0; typed=40 behaves as L=16.
- Reset mid-press: assert reset while button high with counts nonzero -> all outputs 0 immediately; no accept until button_pressed falls and rises again.
